// File: rtl/axi4_pkg.sv
// Shared AXI4 field widths and encodings used by the DMA read path.
package axi4_pkg;
    localparam int         SIZE_BITS  = 3;
    localparam int         LEN_BITS   = 8;
    localparam logic [1:0] BURST_INCR = 2'b01;
endpackage

// File: rtl/dmac_addr_gen.sv
// Splits the remaining transfer into the next INCR burst that stays inside
// one MAX_BURST_LEN-beat aligned window.
module dmac_addr_gen
    import axi4_pkg::*;
#(
    parameter int ADDR_WD       = 32,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic [ADDR_WD-1:0]   addr,
    input  logic [ADDR_WD-1:0]   length,
    input  logic [SIZE_BITS-1:0] size,
    output logic [ADDR_WD-1:0]   next_addr,
    output logic [ADDR_WD-1:0]   next_length,
    output logic [LEN_BITS-1:0]  burst_len,
    output logic                 req_last
);
    localparam logic [ADDR_WD-1:0] ONE = ADDR_WD'(1);

    logic [ADDR_WD-1:0] window;
    logic [ADDR_WD-1:0] room;
    logic [ADDR_WD-1:0] chunk;
    logic [ADDR_WD-1:0] last_byte;
    logic [ADDR_WD-1:0] beats_m1;
    logic               unused_hi;

    always_comb begin
        window      = ADDR_WD'(MAX_BURST_LEN) << size;
        room        = window - (addr & (window - ONE));
        req_last    = (length <= room);
        chunk       = req_last ? length : room;
        // Beat count spans first to last touched beat, so partial beats count whole
        last_byte   = addr + chunk - ONE;
        beats_m1    = (last_byte >> size) - (addr >> size);
        next_addr   = addr + chunk;
        next_length = length - chunk;
    end

    // A window never holds more than MAX_BURST_LEN (<= 256) beats
    assign burst_len = beats_m1[LEN_BITS-1:0];
    assign unused_hi = ^beats_m1[ADDR_WD-1:LEN_BITS];
endmodule

// File: rtl/dmac_burst_issuer.sv
// Read-side burst sequencer: turns one transfer command into AXI4 AR bursts
// and tracks outstanding bursts until the command has fully completed.
module dmac_burst_issuer
    import axi4_pkg::*;
#(
    parameter int ADDR_WD         = 32,
    parameter int MAX_BURST_LEN   = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADDR_WD-1:0]   cmd_addr,
    input  logic [ADDR_WD-1:0]   cmd_length,
    input  logic [SIZE_BITS-1:0] cmd_size,
    output logic                 arvalid,
    input  logic                 arready,
    output logic [ADDR_WD-1:0]   araddr,
    output logic [LEN_BITS-1:0]  arlen,
    output logic [SIZE_BITS-1:0] arsize,
    output logic [1:0]           arburst,
    output logic                 ar_last,
    input  logic                 burst_cpl,
    output logic                 busy,
    output logic                 done
);
    localparam int                CNT_WD  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_WD-1:0] CNT_MAX = CNT_WD'(MAX_OUTSTANDING);
    localparam logic [CNT_WD-1:0] CNT_ONE = CNT_WD'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t               state, state_nxt;
    logic [ADDR_WD-1:0]   cur_addr, cur_len;
    logic [SIZE_BITS-1:0] cur_size;
    logic [CNT_WD-1:0]    cnt;
    logic [ADDR_WD-1:0]   next_addr, next_length;
    logic [LEN_BITS-1:0]  burst_len;
    logic                 req_last;
    logic                 cmd_fire, ar_fire, cpl_take;

    dmac_addr_gen #(
        .ADDR_WD      (ADDR_WD),
        .MAX_BURST_LEN(MAX_BURST_LEN)
    ) u_addr_gen (
        .addr       (cur_addr),
        .length     (cur_len),
        .size       (cur_size),
        .next_addr  (next_addr),
        .next_length(next_length),
        .burst_len  (burst_len),
        .req_last   (req_last)
    );

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        arvalid   = 1'b0;
        arlen     = '0;
        ar_last   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = (cmd_length == '0) ? DRAIN : ISSUE;
            end
            ISSUE: begin
                // cnt only rises on a handshake, so arvalid cannot drop while waiting
                arvalid = (cnt < CNT_MAX);
                arlen   = burst_len;
                ar_last = req_last;
                if (arvalid && arready && req_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if ((cnt == '0) || ((cnt == CNT_ONE) && burst_cpl)) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cmd_fire = cmd_valid && cmd_ready;
    assign ar_fire  = arvalid && arready;
    assign cpl_take = burst_cpl && (cnt != '0);
    assign araddr   = cur_addr;
    assign arsize   = cur_size;
    assign arburst  = BURST_INCR;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cur_addr <= '0;
            cur_len  <= '0;
            cur_size <= '0;
            cnt      <= '0;
        end else begin
            state <= state_nxt;
            if (cmd_fire) begin
                cur_addr <= cmd_addr;
                cur_len  <= cmd_length;
                cur_size <= cmd_size;
            end else if (ar_fire) begin
                cur_addr <= next_addr;
                cur_len  <= next_length;
            end
            if (ar_fire && !cpl_take) cnt <= cnt + CNT_ONE;
            else if (!ar_fire && cpl_take) cnt <= cnt - CNT_ONE;
        end
    end
endmodule

// File: tb/tb_dmac_burst_issuer.sv
// Directed and randomized checks of dmac_burst_issuer against a burst-list
// reference model computed from address/length arithmetic.
module tb_dmac_burst_issuer;
    import axi4_pkg::*;

    localparam int AW  = 32;
    localparam int MBL = 16;
    localparam int MOS = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 cmd_valid = 1'b0;
    logic                 cmd_ready;
    logic [AW-1:0]        cmd_addr = '0;
    logic [AW-1:0]        cmd_length = '0;
    logic [SIZE_BITS-1:0] cmd_size = '0;
    logic                 arvalid;
    logic                 arready = 1'b0;
    logic [AW-1:0]        araddr;
    logic [LEN_BITS-1:0]  arlen;
    logic [SIZE_BITS-1:0] arsize;
    logic [1:0]           arburst;
    logic                 ar_last;
    logic                 burst_cpl = 1'b0;
    logic                 busy;
    logic                 done;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    longint unsigned q_addr[$];
    int              q_len[$];
    bit              q_last[$];

    dmac_burst_issuer #(
        .ADDR_WD        (AW),
        .MAX_BURST_LEN  (MBL),
        .MAX_OUTSTANDING(MOS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_length(cmd_length),
        .cmd_size  (cmd_size),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .ar_last   (ar_last),
        .burst_cpl (burst_cpl),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, ".arvalid"},   64'(arvalid),   64'd0);
        check({tag, ".busy"},      64'(busy),      64'd0);
        check({tag, ".done"},      64'(done),      64'd0);
        check({tag, ".ar_last"},   64'(ar_last),   64'd0);
        check({tag, ".araddr"},    64'(araddr),    64'd0);
        check({tag, ".arlen"},     64'(arlen),     64'd0);
        check({tag, ".arsize"},    64'(arsize),    64'd0);
        check({tag, ".arburst"},   64'(arburst),   64'd1);
    endtask

    // Reference burst list: walk the byte range window by window.
    task automatic build_bursts(input longint unsigned addr, input longint unsigned len,
                                input int size);
        longint unsigned a, rem, window, beat, boundary, chunk, first_beat_addr, beats;
        q_addr.delete();
        q_len.delete();
        q_last.delete();
        a      = addr;
        rem    = len;
        window = 64'(MBL) << size;
        beat   = 64'(1) << size;
        while (rem > 0) begin
            boundary        = (a / window + 1) * window;
            chunk           = (boundary - a < rem) ? boundary - a : rem;
            first_beat_addr = (a / beat) * beat;
            beats           = (a + chunk - first_beat_addr + beat - 1) / beat;
            q_addr.push_back(a);
            q_len.push_back(int'(beats) - 1);
            q_last.push_back(chunk == rem);
            a   = a + chunk;
            rem = rem - chunk;
        end
    endtask

    task automatic run_cmd(input string tag, input longint unsigned addr,
                           input longint unsigned len, input int size,
                           input int ready_pct, input int cpl_pct,
                           input int ready_hold, input int cpl_hold, input bit stray);
        int  issued, outst, old_outst, n;
        bit  finished, exp_valid, exp_done, cpl;
        build_bursts(addr, len, size);
        n = q_addr.size();
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_addr   = AW'(addr);
        cmd_length = AW'(len);
        cmd_size   = SIZE_BITS'(size);
        arready    = 1'b0;
        burst_cpl  = 1'b0;
        #1;
        check({tag, ".accept_ready"}, 64'(cmd_ready), 64'd1);
        @(posedge clk);
        issued   = 0;
        outst    = 0;
        finished = 1'b0;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            cmd_addr  = $urandom;
            arready   = (cyc >= ready_hold) && ($urandom_range(99) < ready_pct);
            cpl       = (cyc >= cpl_hold) && (outst > 0 || stray) && ($urandom_range(99) < cpl_pct);
            burst_cpl = cpl;
            exp_valid = (issued < n) && (outst < MOS);
            exp_done  = (issued == n) && (outst == 0 || (outst == 1 && cpl));
            #1;
            check({tag, ".arvalid"},   64'(arvalid),   64'(exp_valid));
            check({tag, ".done"},      64'(done),      64'(exp_done));
            check({tag, ".busy"},      64'(busy),      64'd1);
            check({tag, ".cmd_ready"}, 64'(cmd_ready), 64'd0);
            if (exp_valid) begin
                check({tag, ".araddr"},  64'(araddr),  q_addr[issued]);
                check({tag, ".arlen"},   64'(arlen),   64'(q_len[issued]));
                check({tag, ".ar_last"}, 64'(ar_last), 64'(q_last[issued]));
                check({tag, ".arsize"},  64'(arsize),  64'(size));
                check({tag, ".arburst"}, 64'(arburst), 64'(BURST_INCR));
            end
            @(posedge clk);
            old_outst = outst;
            if (exp_valid && arready) begin
                issued++;
                outst++;
            end
            if (cpl && old_outst > 0) outst--;
            if (exp_done) finished = 1'b1;
        end
        if (!finished) check({tag, ".timeout"}, 64'd0, 64'd1);
        @(negedge clk);
        arready   = 1'b0;
        burst_cpl = 1'b0;
        #1;
        check({tag, ".ready_after"}, 64'(cmd_ready), 64'd1);
        check({tag, ".busy_after"},  64'(busy),      64'd0);
        check({tag, ".done_after"},  64'(done),      64'd0);
    endtask

    initial begin
        #3;
        check_reset_values("por");
        @(negedge clk);
        rst = 1'b0;

        // Aligned: four full bursts, immediate completions
        run_cmd("aligned", 64'h1000, 64'h100, 2, 100, 100, 0, 0, 1'b0);
        // Unaligned: shortened first burst then a single-beat tail
        run_cmd("unaligned", 64'h1004, 64'h40, 2, 100, 100, 0, 0, 1'b0);
        // Outstanding limit: completions withheld for a while
        run_cmd("limit", 64'h4000, 64'h200, 2, 100, 40, 0, 10, 1'b0);
        // Backpressure: arready low for the first 5 cycles
        run_cmd("backpressure", 64'h8010, 64'h80, 2, 100, 100, 5, 0, 1'b0);

        // Stray completion while idle, then zero-length command with strays
        @(negedge clk);
        burst_cpl = 1'b1;
        #1;
        check("stray_idle.cmd_ready", 64'(cmd_ready), 64'd1);
        check("stray_idle.busy",      64'(busy),      64'd0);
        run_cmd("zero_len", 64'h2000, 64'h0, 2, 100, 100, 0, 0, 1'b1);
        // Counter must still be 0: both bursts issue before any completion
        run_cmd("after_zero", 64'h3000, 64'h100, 2, 100, 100, 0, 6, 1'b0);

        // Reset in the middle of ISSUE with two bursts outstanding
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_addr   = 32'h2000;
        cmd_length = 32'h200;
        cmd_size   = 3'd2;
        arready    = 1'b1;
        burst_cpl  = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("midreset.arvalid_limited", 64'(arvalid), 64'd0);
        check("midreset.busy",            64'(busy),    64'd1);
        #1 rst = 1'b1;
        #1;
        check_reset_values("midreset");
        arready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_cmd("post_reset", 64'h5000, 64'h100, 2, 100, 100, 0, 6, 1'b0);

        // Randomized commands
        for (int i = 0; i < 8; i++) begin
            run_cmd($sformatf("rand%0d", i), 64'($urandom_range(32'h7fff_ffff, 0)),
                    64'($urandom_range(600, 0)), int'($urandom_range(3, 0)),
                    70, 50, 0, 0, bit'($urandom_range(1, 0)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
